ternary_seq_ctrl: RTL and testbench

Top-level sequencer for the tiny ternary matrix-vector engine. It decodes 16-bit command words from the combined `{ui_in, uio_in}` bus and latches the layer configuration. It then runs the weight loader, the multiply-accumulate pass and the output-streaming pass in order, driving per-cycle index counters for each phase. It replaces the two-state IDLE/LOAD control currently in the top level and adds the MULT and OUT phases.

---
 rtl/ternary_pkg.sv | 35 +++
 rtl/ternary_idx_cnt.sv | 31 +++
 rtl/ternary_seq_ctrl.sv | 170 +++++++++++++++++
 tb/tb_ternary_seq_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ternary_pkg.sv
// Shared types and constants for the ternary matrix-vector engine sequencer.
package ternary_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_MULT = 2'd2,
    ST_OUT  = 2'd3
  } state_t;

  localparam logic [3:0] OP_LOAD  = 4'hA;
  localparam logic [3:0] OP_RUN   = 4'h5;
  localparam logic [3:0] OP_ABORT = 4'hF;

  localparam int unsigned CMD_OP_MSB  = 15;
  localparam int unsigned CMD_OP_LSB  = 12;
  localparam int unsigned CMD_CFG_MSB = 11;
  localparam int unsigned CMD_CFG_LSB = 5;
  localparam int unsigned CMD_PAD_MSB = 4;

  localparam int unsigned CFG_W       = 7;
  localparam int unsigned CFG_IN_MSB  = 6;
  localparam int unsigned CFG_IN_LSB  = 3;
  localparam int unsigned CFG_OUT_MSB = 2;
  localparam int unsigned CFG_OUT_LSB = 0;

  localparam logic [CFG_W-1:0] CFG_RESET = 7'h7F;

  // cfg fields hold length-1; clamp to the largest index the hardware supports
  function automatic int unsigned clamp_last(input int unsigned field,
                                             input int unsigned max_len);
    return (field > max_len - 1) ? max_len - 1 : field;
  endfunction

endpackage

// File: rtl/ternary_idx_cnt.sv
// Clear/enable up-counter with a terminal-count flag against a runtime limit.
module ternary_idx_cnt
  import ternary_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic [W-1:0] i_last,
  output logic [W-1:0] o_idx,
  output logic         o_tc
);

  logic [W-1:0] r_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx <= '0;
    end else if (i_clr) begin
      r_idx <= '0;
    end else if (i_en) begin
      r_idx <= r_idx + W'(1);
    end
  end

  assign o_idx = r_idx;
  assign o_tc  = (r_idx == i_last);

endmodule

// File: rtl/ternary_seq_ctrl.sv
// Sequencer for the ternary engine: LOAD -> (RUN) MULT -> OUT phases.
// Optional abort opcode enabled by defining TERNARY_SEQ_ABORT_EN.
module ternary_seq_ctrl
  import ternary_pkg::*;
#(
  parameter int unsigned MAX_IN_LEN  = 16,
  parameter int unsigned MAX_OUT_LEN = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [15:0]                    cmd_in,
  input  logic                           load_done,
  output logic                           load_ena,
  output logic [6:0]                     load_param,
  output logic                           mult_ena,
  output logic                           mult_clr,
  output logic [$clog2(MAX_IN_LEN)-1:0]  mult_idx,
  output logic                           out_ena,
  output logic [$clog2(MAX_OUT_LEN)-1:0] out_idx,
  output logic                           busy,
  output logic                           wvalid,
  output logic                           err
);

  localparam int unsigned IW = $clog2(MAX_IN_LEN);
  localparam int unsigned OW = $clog2(MAX_OUT_LEN);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CFG_W-1:0]   r_load_param;
  logic [CFG_W-1:0]   w_param_nxt;
  logic               r_wvalid;
  logic               w_wvalid_nxt;
  logic               r_err;
  logic               w_err_nxt;

  logic [3:0]         w_op;
  logic [CFG_W-1:0]   w_cfg;
  logic [IW-1:0]      w_in_last;
  logic [OW-1:0]      w_out_last;
  logic [IW-1:0]      w_mult_idx;
  logic [OW-1:0]      w_out_idx;
  logic               w_mult_tc;
  logic               w_out_tc;
  logic               w_mult_cnt_clr;
  logic               w_out_cnt_clr;

  assign w_op  = cmd_in[CMD_OP_MSB:CMD_OP_LSB];
  assign w_cfg = cmd_in[CMD_CFG_MSB:CMD_CFG_LSB];

  assign w_in_last  = IW'(clamp_last(32'(r_load_param[CFG_IN_MSB:CFG_IN_LSB]), MAX_IN_LEN));
  assign w_out_last = OW'(clamp_last(32'(r_load_param[CFG_OUT_MSB:CFG_OUT_LSB]), MAX_OUT_LEN));

  // Clearing on the next state keeps each index at 0 whenever its phase is not running.
  assign w_mult_cnt_clr = (w_state_nxt != ST_MULT);
  assign w_out_cnt_clr  = (w_state_nxt != ST_OUT);

  ternary_idx_cnt #(.W(IW)) u_mult_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_mult_cnt_clr),
    .i_en   (r_state == ST_MULT),
    .i_last (w_in_last),
    .o_idx  (w_mult_idx),
    .o_tc   (w_mult_tc)
  );

  ternary_idx_cnt #(.W(OW)) u_out_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_out_cnt_clr),
    .i_en   (r_state == ST_OUT),
    .i_last (w_out_last),
    .o_idx  (w_out_idx),
    .o_tc   (w_out_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_load_param <= CFG_RESET;
      r_wvalid     <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_load_param <= w_param_nxt;
      r_wvalid     <= w_wvalid_nxt;
      r_err        <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_param_nxt  = r_load_param;
    w_wvalid_nxt = r_wvalid;
    w_err_nxt    = r_err;

    case (r_state)
      ST_IDLE: begin
        if (w_op == OP_LOAD) begin
          w_param_nxt  = w_cfg;
          w_wvalid_nxt = 1'b0;
          w_err_nxt    = 1'b0;
          w_state_nxt  = ST_LOAD;
        end else if (w_op == OP_RUN) begin
          if (r_wvalid) begin
            w_err_nxt   = 1'b0;
            w_state_nxt = ST_MULT;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        if (load_done) begin
          w_wvalid_nxt = 1'b1;
          w_state_nxt  = ST_IDLE;
        end
      end
      ST_MULT: begin
        if (w_mult_tc) begin
          w_state_nxt = ST_OUT;
        end
      end
      ST_OUT: begin
        if (w_out_tc) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

`ifdef TERNARY_SEQ_ABORT_EN
    // Abort overrides everything above, including a coincident load_done.
    if (w_op == OP_ABORT) begin
      w_state_nxt = ST_IDLE;
      if (r_state == ST_LOAD) begin
        w_wvalid_nxt = 1'b0;
      end
      if (r_state == ST_IDLE) begin
        w_err_nxt = 1'b0;
      end
    end
`endif
  end

  always_comb begin
    load_ena   = (r_state == ST_LOAD);
    mult_ena   = (r_state == ST_MULT);
    mult_clr   = (r_state == ST_MULT) && (w_mult_idx == '0);
    out_ena    = (r_state == ST_OUT);
    busy       = (r_state != ST_IDLE);
    load_param = r_load_param;
    wvalid     = r_wvalid;
    err        = r_err;
    mult_idx   = w_mult_idx;
    out_idx    = w_out_idx;
  end

`ifdef TERNARY_SEQ_ABORT_EN
  logic w_unused;
  assign w_unused = ^cmd_in[CMD_PAD_MSB:0];
`else
  logic w_unused;
  assign w_unused = ^{cmd_in[CMD_PAD_MSB:0], (w_op == OP_ABORT)};
`endif

endmodule

// File: tb/tb_ternary_seq_ctrl.sv
// Self-checking bench for ternary_seq_ctrl: directed table, corner sequences, random vs model.
module tb_ternary_seq_ctrl;

  localparam int MAXI = 16;
  localparam int MAXO = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] cmd_in;
  logic        load_done;
  logic        load_ena;
  logic [6:0]  load_param;
  logic        mult_ena;
  logic        mult_clr;
  logic [3:0]  mult_idx;
  logic        out_ena;
  logic [2:0]  out_idx;
  logic        busy;
  logic        wvalid;
  logic        err;

  int n_checks = 0;
  int n_errors = 0;

  ternary_seq_ctrl #(.MAX_IN_LEN(MAXI), .MAX_OUT_LEN(MAXO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_in     (cmd_in),
    .load_done  (load_done),
    .load_ena   (load_ena),
    .load_param (load_param),
    .mult_ena   (mult_ena),
    .mult_clr   (mult_clr),
    .mult_idx   (mult_idx),
    .out_ena    (out_ena),
    .out_idx    (out_idx),
    .busy       (busy),
    .wvalid     (wvalid),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Reference model: mode 0 idle, 1 loading, 2 running; m_t counts cycles into a run.
  int         m_mode;
  int         m_t;
  int         m_il;
  int         m_ol;
  bit         m_wv;
  bit         m_er;
  logic [6:0] m_prm;

  task automatic model_reset();
    m_mode = 0; m_t = 0; m_il = 0; m_ol = 0;
    m_wv = 1'b0; m_er = 1'b0; m_prm = 7'h7F;
  endtask

  task automatic model_step(input logic [3:0] op, input logic [6:0] cfg, input logic ld);
    bit ab;
    ab = 1'b0;
`ifdef TERNARY_SEQ_ABORT_EN
    ab = (op == 4'hF);
`endif
    if (ab) begin
      if (m_mode == 1) m_wv = 1'b0;
      if (m_mode == 0) m_er = 1'b0;
      m_mode = 0;
    end else begin
      case (m_mode)
        0: begin
          if (op == 4'hA) begin
            m_prm = cfg; m_wv = 1'b0; m_er = 1'b0; m_mode = 1;
          end else if (op == 4'h5) begin
            if (m_wv) begin
              m_il = int'(m_prm[6:3]) + 1; if (m_il > MAXI) m_il = MAXI;
              m_ol = int'(m_prm[2:0]) + 1; if (m_ol > MAXO) m_ol = MAXO;
              m_t = 0; m_er = 1'b0; m_mode = 2;
            end else begin
              m_er = 1'b1;
            end
          end
        end
        1: if (ld) begin m_mode = 0; m_wv = 1'b1; end
        default: begin
          m_t++;
          if (m_t == m_il + m_ol) m_mode = 0;
        end
      endcase
    end
  endtask

  task automatic chk(input string nm, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, got, exp);
    end
  endtask

  task automatic check_model(input string tag);
    bit e_mult, e_out;
    e_mult = (m_mode == 2) && (m_t < m_il);
    e_out  = (m_mode == 2) && (m_t >= m_il);
    chk({tag, "_busy"},     int'(busy),       int'(m_mode != 0));
    chk({tag, "_load_ena"}, int'(load_ena),   int'(m_mode == 1));
    chk({tag, "_mult_ena"}, int'(mult_ena),   int'(e_mult));
    chk({tag, "_mult_clr"}, int'(mult_clr),   int'(e_mult && m_t == 0));
    chk({tag, "_mult_idx"}, int'(mult_idx),   e_mult ? m_t : 0);
    chk({tag, "_out_ena"},  int'(out_ena),    int'(e_out));
    chk({tag, "_out_idx"},  int'(out_idx),    e_out ? m_t - m_il : 0);
    chk({tag, "_wvalid"},   int'(wvalid),     int'(m_wv));
    chk({tag, "_err"},      int'(err),        int'(m_er));
    chk({tag, "_param"},    int'(load_param), int'(m_prm));
  endtask

  // Called just after a negedge; returns at the following negedge with the model advanced.
  task automatic drive(input logic [3:0] op, input logic [6:0] cfg, input logic ld);
    cmd_in    = {op, cfg, 5'($urandom)};
    load_done = ld;
    @(posedge clk);
    model_step(op, cfg, ld);
    @(negedge clk);
  endtask

  task automatic cycle(input string tag, input logic [3:0] op, input logic [6:0] cfg, input logic ld);
    drive(op, cfg, ld);
    check_model(tag);
  endtask

  typedef struct {
    logic [3:0] op;  logic [6:0] cfg; logic ld;
    logic busy; logic lena; logic mena; logic mclr; int midx;
    logic oena; int oidx; logic wv; logic er; logic [6:0] prm;
  } vec_t;

  vec_t tbl [14];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int cnt;
    int r;
    logic [3:0] op;

    tbl[0]  = '{4'h5, 7'h00, 1'b0, 0,0,0,0, 0, 0, 0, 0, 1, 7'h7F};
    tbl[1]  = '{4'h0, 7'h00, 1'b0, 0,0,0,0, 0, 0, 0, 0, 1, 7'h7F};
    tbl[2]  = '{4'hA, 7'h1A, 1'b0, 1,1,0,0, 0, 0, 0, 0, 0, 7'h1A};
    tbl[3]  = '{4'h0, 7'h00, 1'b0, 1,1,0,0, 0, 0, 0, 0, 0, 7'h1A};
    tbl[4]  = '{4'h0, 7'h00, 1'b1, 0,0,0,0, 0, 0, 0, 1, 0, 7'h1A};
    tbl[5]  = '{4'h0, 7'h00, 1'b1, 0,0,0,0, 0, 0, 0, 1, 0, 7'h1A};
    tbl[6]  = '{4'h5, 7'h55, 1'b0, 1,0,1,1, 0, 0, 0, 1, 0, 7'h1A};
    tbl[7]  = '{4'hA, 7'h00, 1'b0, 1,0,1,0, 1, 0, 0, 1, 0, 7'h1A};
    tbl[8]  = '{4'h0, 7'h00, 1'b1, 1,0,1,0, 2, 0, 0, 1, 0, 7'h1A};
    tbl[9]  = '{4'h0, 7'h00, 1'b0, 1,0,1,0, 3, 0, 0, 1, 0, 7'h1A};
    tbl[10] = '{4'h0, 7'h00, 1'b0, 1,0,0,0, 0, 1, 0, 1, 0, 7'h1A};
    tbl[11] = '{4'h0, 7'h00, 1'b0, 1,0,0,0, 0, 1, 1, 1, 0, 7'h1A};
    tbl[12] = '{4'h0, 7'h00, 1'b0, 1,0,0,0, 0, 1, 2, 1, 0, 7'h1A};
    tbl[13] = '{4'h0, 7'h00, 1'b0, 0,0,0,0, 0, 0, 0, 1, 0, 7'h1A};

    rst_n = 1'b0; cmd_in = '0; load_done = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_model("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      string t;
      drive(tbl[i].op, tbl[i].cfg, tbl[i].ld);
      t = $sformatf("tbl%0d", i);
      chk({t, "_busy"},     int'(busy),       int'(tbl[i].busy));
      chk({t, "_load_ena"}, int'(load_ena),   int'(tbl[i].lena));
      chk({t, "_mult_ena"}, int'(mult_ena),   int'(tbl[i].mena));
      chk({t, "_mult_clr"}, int'(mult_clr),   int'(tbl[i].mclr));
      chk({t, "_mult_idx"}, int'(mult_idx),   tbl[i].midx);
      chk({t, "_out_ena"},  int'(out_ena),    int'(tbl[i].oena));
      chk({t, "_out_idx"},  int'(out_idx),    tbl[i].oidx);
      chk({t, "_wvalid"},   int'(wvalid),     int'(tbl[i].wv));
      chk({t, "_err"},      int'(err),        int'(tbl[i].er));
      chk({t, "_param"},    int'(load_param), int'(tbl[i].prm));
    end

    // Full-size load with load_done arriving 20 cycles after the command.
    cnt = 0;
    cycle("ld20", 4'hA, 7'h7F, 1'b0);
    if (load_ena) cnt++;
    for (int i = 0; i < 19; i++) begin
      cycle("ld20", 4'h0, 7'h00, 1'b0);
      if (load_ena) cnt++;
    end
    cycle("ld20", 4'h0, 7'h00, 1'b1);
    if (load_ena) cnt++;
    chk("ld20_load_ena_cycles", cnt, 20);
    chk("ld20_param", int'(load_param), 32'h7F);
    chk("ld20_wvalid", int'(wvalid), 1);
    chk("ld20_busy", int'(busy), 0);

    // Reset asserted asynchronously while streaming out_idx 1.
    cycle("rst_run", 4'h5, 7'h00, 1'b0);
    for (int i = 0; i < 64 && !(m_mode == 2 && m_t == m_il + 1); i++)
      cycle("rst_run", 4'h0, 7'h00, 1'b0);
    chk("rst_at_out1", int'(out_idx), 1);
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_model("async_rst");
    chk("async_rst_wvalid", int'(wvalid), 0);
    @(negedge clk);
    rst_n = 1'b1;

`ifdef TERNARY_SEQ_ABORT_EN
    cycle("abt", 4'hA, 7'h08, 1'b0);
    cycle("abt", 4'h0, 7'h00, 1'b0);
    cycle("abt", 4'hF, 7'h00, 1'b1);
    chk("abt_load_busy", int'(busy), 0);
    chk("abt_load_wvalid", int'(wvalid), 0);
    cycle("abt", 4'hA, 7'h08, 1'b0);
    cycle("abt", 4'h0, 7'h00, 1'b1);
    cycle("abt", 4'h5, 7'h00, 1'b0);
    cycle("abt", 4'h0, 7'h00, 1'b0);
    cycle("abt", 4'hF, 7'h00, 1'b0);
    chk("abt_mult_busy", int'(busy), 0);
    chk("abt_mult_ena", int'(mult_ena), 0);
    chk("abt_mult_wvalid", int'(wvalid), 1);
`else
    cycle("noabt", 4'hA, 7'h08, 1'b0);
    cycle("noabt", 4'hF, 7'h00, 1'b0);
    chk("noabt_load_ena", int'(load_ena), 1);
    cycle("noabt", 4'h0, 7'h00, 1'b1);
    chk("noabt_wvalid", int'(wvalid), 1);
`endif

    // Random traffic; RUN is frequent so held-RUN back-to-back runs occur.
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 10)      op = 4'hA;
      else if (r < 50) op = 4'h5;
      else if (r < 54) op = 4'hF;
      else if (r < 60) op = 4'($urandom);
      else             op = 4'h0;
      cycle("rnd", op, 7'($urandom), ($urandom_range(0, 7) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
